// File: rtl/cycle_controller.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT.
// Optional performance counters are built when PERF_COUNTER_EN is defined.
module cycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        update_sreg,
  input  logic        halt_instr,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_en,
  output logic        rf_read_en,
  output logic        alu_en,
  output logic        sreg_en,
  output logic        rf_write_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  // Handshake: mem_req is held high every MEMORY cycle; the access completes in
  // the cycle mem_ready is sampled high, and mem_ready wins over a same-cycle timeout.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [8:0] wait_inc;
  logic       mw_q, rw_q;
  logic       fault_q, fault_set;
  logic       arm_q;

  assign wait_inc = {1'b0, wait_q} + 9'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      fault_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      arm_q   <= 1'b1;
      if (fault_set) fault_q <= 1'b1;
      if (state_q == EXECUTE) begin
        mw_q <= mem_write;
        rw_q <= reg_write;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    fault_set = 1'b0;
    case (state_q)
      // arm_q holds the first post-reset edge in IDLE
      IDLE:      if (run && arm_q) state_d = FETCH;
      FETCH:     state_d = DECODE;
      DECODE:    state_d = halt_instr ? HALT : EXECUTE;
      EXECUTE: begin
        wait_d  = '0;
        state_d = (mem_read || mem_write) ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        if (mem_ready) begin
          state_d = WRITEBACK;
        end else if (wait_inc >= TIMEOUT) begin
          state_d   = HALT;
          fault_set = 1'b1;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      WRITEBACK: state_d = run ? FETCH : IDLE;
      HALT:      state_d = HALT;
      default: begin
        state_d   = HALT;
        fault_set = 1'b1;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ir_en       = 1'b0;
    rf_read_en  = 1'b0;
    alu_en      = 1'b0;
    sreg_en     = 1'b0;
    rf_write_en = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      FETCH:   ir_en      = 1'b1;
      DECODE:  rf_read_en = 1'b1;
      EXECUTE: begin
        alu_en  = 1'b1;
        sreg_en = update_sreg;
      end
      MEMORY: begin
        mem_req = 1'b1;
        mem_we  = mw_q;
      end
      WRITEBACK: begin
        pc_en       = 1'b1;
        rf_write_en = rw_q;
      end
      default: ;
    endcase
  end

  assign state  = state_q;
  assign halted = (state_q == HALT);
  assign fault  = fault_q;

`ifdef PERF_COUNTER_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != IDLE && state_q != HALT) cyc_q <= cyc_q + 32'd1;
      if (state_q == WRITEBACK) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cycle_controller.sv
// Directed bench for cycle_controller: expected state trace queued per step,
// popped and compared every cycle, plus per-instruction enable tallies.
module tb_cycle_controller;

`ifdef PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, reset, run;
  logic        mem_read, mem_write, reg_write, update_sreg, halt_instr, mem_ready;
  logic        pc_en, ir_en, rf_read_en, alu_en, sreg_en, rf_write_en;
  logic        mem_req, mem_we, halted, fault;
  logic [2:0]  state;
  logic [31:0] cycle_count, instr_count;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  int n_memreq, n_we, n_rfw, n_pc, n_sreg;

  cycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .update_sreg(update_sreg), .halt_instr(halt_instr), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .rf_read_en(rf_read_en), .alu_en(alu_en),
    .sreg_en(sreg_en), .rf_write_en(rf_write_en), .mem_req(mem_req), .mem_we(mem_we),
    .state(state), .halted(halted), .fault(fault),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  task automatic clear_tally();
    n_memreq = 0; n_we = 0; n_rfw = 0; n_pc = 0; n_sreg = 0;
  endtask

  // n cycles; mem_ready is high only in the cycle after the ready_at-th sample
  task automatic cycle_seq(input int n, input int ready_at, input string tag);
    logic [2:0] e;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_state"}, 32'(state), 32'(e));
      end
      if (mem_req)     n_memreq++;
      if (mem_we)      n_we++;
      if (rf_write_en) n_rfw++;
      if (pc_en)       n_pc++;
      if (sreg_en)     n_sreg++;
      mem_ready = (i == ready_at);
    end
    mem_ready = 1'b0;
  endtask

  task automatic set_instr(input logic rd, input logic wr, input logic rw,
                           input logic us, input logic hl);
    mem_read = rd; mem_write = wr; reg_write = rw; update_sreg = us; halt_instr = hl;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
    set_instr(0, 0, 0, 0, 0);
    clear_tally();
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted_fault", {30'd0, halted, fault}, 32'd0);
    check("rst_enables", {24'd0, pc_en, ir_en, rf_read_en, alu_en, sreg_en, rf_write_en, mem_req, mem_we}, 32'd0);
    check("rst_counts", cycle_count | instr_count, 32'd0);

    // reset release with run high: first edge only arms
    reset = 1'b0; run = 1'b1;
    tick();
    check("post_rst_idle", 32'(state), 32'd0);

    // ADD: no memory, reg_write, update_sreg
    set_instr(0, 0, 1, 1, 0);
    clear_tally();
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    exp_q.push_back(3'd5); exp_q.push_back(3'd1);
    cycle_seq(5, 0, "add");
    check("add_rfw", n_rfw, 1);
    check("add_pc", n_pc, 1);
    check("add_sreg", n_sreg, 1);
    check("add_memreq", n_memreq, 0);
    check("add_cycles", cycle_count, PERF ? 32'd4 : 32'd0);
    check("add_instrs", instr_count, PERF ? 32'd1 : 32'd0);

    // LDUR: ready on the 4th MEMORY cycle
    set_instr(1, 0, 1, 0, 0);
    clear_tally();
    exp_q.push_back(3'd2); exp_q.push_back(3'd3); push_n(3'd4, 4);
    exp_q.push_back(3'd5); exp_q.push_back(3'd1);
    cycle_seq(8, 6, "ldur");
    check("ldur_memreq", n_memreq, 4);
    check("ldur_we", n_we, 0);
    check("ldur_rfw", n_rfw, 1);
    check("ldur_sreg", n_sreg, 0);
    check("ldur_fault", 32'(fault), 32'd0);

    // STUR: ready exactly on the timeout cycle
    set_instr(0, 1, 0, 0, 0);
    clear_tally();
    exp_q.push_back(3'd2); exp_q.push_back(3'd3); push_n(3'd4, 15);
    exp_q.push_back(3'd5); exp_q.push_back(3'd1);
    cycle_seq(19, 17, "edge");
    check("edge_memreq", n_memreq, 15);
    check("edge_we", n_we, 15);
    check("edge_rfw", n_rfw, 0);
    check("edge_fault", 32'(fault), 32'd0);

    // run dropped in EXECUTE: finish through WRITEBACK into IDLE
    set_instr(0, 0, 1, 0, 0);
    clear_tally();
    exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    cycle_seq(2, 0, "drop_a");
    run = 1'b0;
    exp_q.push_back(3'd5); push_n(3'd0, 2);
    cycle_seq(3, 0, "drop_b");
    check("drop_rfw", n_rfw, 1);
    check("drop_halted", 32'(halted), 32'd0);
    check("drop_cycles", cycle_count, PERF ? 32'd35 : 32'd0);
    check("drop_instrs", instr_count, PERF ? 32'd4 : 32'd0);

    // STUR with no ready: timeout fault
    run = 1'b1;
    set_instr(0, 1, 0, 0, 0);
    clear_tally();
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    push_n(3'd4, 15); push_n(3'd6, 3);
    cycle_seq(21, 0, "tmo");
    check("tmo_memreq", n_memreq, 15);
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_halted", 32'(halted), 32'd1);
    clear_tally();
    run = 1'b0;
    exp_q.push_back(3'd6);
    cycle_seq(1, 0, "tmo_r0");
    run = 1'b1;
    push_n(3'd6, 2);
    cycle_seq(2, 0, "tmo_r1");
    check("tmo_memreq_after", n_memreq, 0);
    check("tmo_pc_after", n_pc, 0);

    // reset mid-MEMORY clears state combinationally before the next edge
    reset = 1'b1; tick(); reset = 1'b0; run = 1'b1;
    set_instr(1, 0, 1, 0, 0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd3); push_n(3'd4, 2);
    cycle_seq(6, 0, "mid");
    check("mid_memreq_pre", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_state", 32'(state), 32'd0);
    check("mid_memreq", 32'(mem_req), 32'd0);
    check("mid_flags", {30'd0, halted, fault}, 32'd0);
    check("mid_counts", cycle_count | instr_count, 32'd0);
    tick();

    // halt instruction in DECODE, run toggling ignored
    reset = 1'b0;
    set_instr(0, 0, 0, 0, 1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd6);
    cycle_seq(4, 0, "hlt");
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_fault", 32'(fault), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run = 1'(i % 2);
      exp_q.push_back(3'd6);
      cycle_seq(1, 0, "hlt_tog");
    end
    check("hlt_cycles", cycle_count, PERF ? 32'd2 : 32'd0);
    check("hlt_instrs", instr_count, 32'd0);
    check("hlt_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
